// File: rtl/i2s_dac_serializer_if.sv
// ---------------------------------------------------------------------------
// i2s_dac_serializer_if
//   Parallel sample hand-off from the pedal-board output into the I2S DAC
//   serializer.
//
//   Handshake: a {LDATA, RDATA} pair moves from master to slave on every Clk
//   rising edge where data_valid && data_ready are both high. The master
//   keeps LDATA/RDATA stable while data_valid is high and data_ready is low.
//   data_ready does not depend on data_valid.
//
//   Signals
//     LDATA       master->slave  WIDTH  left sample, two's complement
//     RDATA       master->slave  WIDTH  right sample, two's complement
//     data_valid  master->slave  1      LDATA/RDATA valid this cycle
//     data_ready  slave->master  1      slave can take a pair this cycle
//
//   Modports: master (sample source), slave (serializer).
// ---------------------------------------------------------------------------
interface i2s_dac_serializer_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] LDATA;
    logic [WIDTH-1:0] RDATA;
    logic             data_valid;
    logic             data_ready;

    modport master (
        output LDATA,
        output RDATA,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  LDATA,
        input  RDATA,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/i2s_dac_serializer.sv
// ---------------------------------------------------------------------------
// i2s_dac_serializer
//   Transmit half of the codec audio path. Takes parallel L/R samples and
//   shifts them out MSB-first in I2S format on AUD_DACDAT. The codec is bus
//   master: AUD_BCLK and AUD_DACLRCK are asynchronous inputs oversampled in
//   the Clk domain.
//
//   Optional feature macro: I2S_UNDERRUN_HOLD_EN
//     defined   : an underrun frame replays the last transmitted {L,R}
//     undefined : an underrun frame transmits zeros (mute)
//
//   Ports
//     Clk            in   1      system clock (>= 4x BCLK)
//     Reset_n        in   1      asynchronous reset, active-low
//     smp            slave       sample handshake (LDATA, RDATA, data_valid,
//                                data_ready)
//     AUD_BCLK       in   1      codec bit clock (async)
//     AUD_DACLRCK    in   1      codec frame clock (async), low = left
//     AUD_DACDAT     out  1      serial data to codec
//     frame_start    out  1      1-Clk pulse at each left-channel start
//     underrun       out  1      1-Clk pulse: frame began with no sample held
//     underrun_count out  8      saturating underrun counter
//     fsm_state      out  2      channel FSM state (0 idle, 1 left, 2 right)
// ---------------------------------------------------------------------------
module i2s_dac_serializer #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    i2s_dac_serializer_if.slave   smp,
    input  logic                  AUD_BCLK,
    input  logic                  AUD_DACLRCK,
    output logic                  AUD_DACDAT,
    output logic                  frame_start,
    output logic                  underrun,
    output logic [7:0]            underrun_count,
    output logic [1:0]            fsm_state
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    // ------------------------------------------------------------------
    // Codec clock synchronizers; bit 0 is the newest sample.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] bclk_sync;
    logic [SYNC_STAGES-1:0] lrck_sync;
    logic                   bclk_fall;
    logic                   lrck_fall;
    logic                   lrck_rise;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], AUD_BCLK};
            lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], AUD_DACLRCK};
        end
    end

    assign bclk_fall =  bclk_sync[SYNC_STAGES-1] & ~bclk_sync[SYNC_STAGES-2];
    assign lrck_fall =  lrck_sync[SYNC_STAGES-1] & ~lrck_sync[SYNC_STAGES-2];
    assign lrck_rise = ~lrck_sync[SYNC_STAGES-1] &  lrck_sync[SYNC_STAGES-2];

    // ------------------------------------------------------------------
    // Holding register and frame bookkeeping
    // ------------------------------------------------------------------
    logic             hold_full;
    logic [WIDTH-1:0] hold_l;
    logic [WIDTH-1:0] hold_r;
    logic [WIDTH-1:0] frame_r;
    logic [WIDTH-1:0] fill_l;
    logic [WIDTH-1:0] fill_r;
    logic [WIDTH-1:0] word_l;
    logic [WIDTH-1:0] word_r;
    logic             accept;

    assign smp.data_ready = ~hold_full;
    assign accept         = smp.data_valid & ~hold_full;

`ifdef I2S_UNDERRUN_HOLD_EN
    logic [WIDTH-1:0] last_l;
    logic [WIDTH-1:0] last_r;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            last_l <= '0;
            last_r <= '0;
        end else if (lrck_fall && hold_full) begin
            last_l <= hold_l;
            last_r <= hold_r;
        end
    end

    assign fill_l = last_l;
    assign fill_r = last_r;
`else
    assign fill_l = '0;
    assign fill_r = '0;
`endif

    // Words for the frame starting at this lrck_fall.
    assign word_l = hold_full ? hold_l : fill_l;
    assign word_r = hold_full ? hold_r : fill_r;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hold_full      <= 1'b0;
            hold_l         <= '0;
            hold_r         <= '0;
            frame_r        <= '0;
            frame_start    <= 1'b0;
            underrun       <= 1'b0;
            underrun_count <= 8'd0;
        end else begin
            frame_start <= lrck_fall;
            underrun    <= lrck_fall & ~hold_full;
            if (lrck_fall) begin
                frame_r <= word_r;
                if (hold_full) begin
                    hold_full <= 1'b0;
                end else if (underrun_count != 8'hFF) begin
                    underrun_count <= underrun_count + 8'd1;
                end
            end
            // An accept coinciding with lrck_fall only happens while empty,
            // so the word waits in the holding register for the next frame.
            if (accept) begin
                hold_full <= 1'b1;
                hold_l    <= smp.LDATA;
                hold_r    <= smp.RDATA;
            end
        end
    end

    // ------------------------------------------------------------------
    // Channel FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    logic load_l;
    logic load_r;
    logic shift_tick;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (lrck_fall) state_d = ST_LEFT;
            ST_LEFT: begin
                if (lrck_rise)      state_d = ST_RIGHT;
                else if (lrck_fall) state_d = ST_LEFT;
            end
            ST_RIGHT: if (lrck_fall) state_d = ST_LEFT;
            default:  state_d = ST_IDLE;
        endcase
    end

    // A channel edge takes priority over a coincident bclk_fall; that
    // BCLK period is the I2S one-bit delay slot.
    always_comb begin
        load_l     = lrck_fall;
        load_r     = lrck_rise && (state_q == ST_LEFT);
        shift_tick = bclk_fall && !lrck_fall && !lrck_rise && (state_q != ST_IDLE);
    end

    assign fsm_state = state_q;

    // ------------------------------------------------------------------
    // Shift register
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] shift_q;
    logic [CNT_W-1:0] bit_cnt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            shift_q    <= '0;
            bit_cnt    <= '0;
            AUD_DACDAT <= 1'b0;
        end else if (load_l) begin
            shift_q <= word_l;
            bit_cnt <= CNT_W'(WIDTH);
        end else if (load_r) begin
            shift_q <= frame_r;
            bit_cnt <= CNT_W'(WIDTH);
        end else if (shift_tick) begin
            if (bit_cnt != '0) begin
                AUD_DACDAT <= shift_q[WIDTH-1];
                shift_q    <= {shift_q[WIDTH-2:0], 1'b0};
                bit_cnt    <= bit_cnt - CNT_W'(1);
            end else begin
                // Slots past the word length are padded with zeros.
                AUD_DACDAT <= 1'b0;
            end
        end
    end

endmodule
